// File: rtl/kpg_prefix_adder_pipe.sv
// kpg_prefix_adder_pipe: pipelined Kogge-Stone KPG adder with valid/ready stream; KPG_OVF_EN adds the ovf port
module kpg_prefix_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef KPG_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NG = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam logic [1:0] K = 2'b00, P = 2'b01, G = 2'b10;
  typedef logic [WIDTH:0][1:0] kvec_t;
  function automatic logic [1:0] op(logic [1:0] hi, logic [1:0] lo);
    return (hi == P) ? lo : hi;
  endfunction
  function automatic kvec_t levels(kvec_t x, int lo, int hi);
    kvec_t y, t;
    y = x;
    for (int l = lo; l < hi; l++) begin
      t = y;
      for (int j = (1 << l); j <= WIDTH; j++) t[j] = op(y[j], y[j - (1 << l)]);
      y = t;
    end
    return y;
  endfunction
  kvec_t            k0, kf;
  kvec_t            k_q [NG];
  logic [WIDTH-1:0] p_q [NG];
  logic             v_q [NG];
  logic [WIDTH-1:0] c;
  logic             cout_d, en;
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  // per-bit classification; entry 0 holds cin as bit -1
  always_comb begin
    k0[0] = cin ? G : K;
    for (int i = 0; i < WIDTH; i++) k0[i+1] = {a[i] & b[i], a[i] ^ b[i]};
  end
  // final group: remaining levels, carries, sum and carry out
  always_comb begin
    kf = levels(k_q[NG-1], (NG - 1) * REG_EVERY, LEVELS);
    for (int i = 0; i < WIDTH; i++) c[i] = (kf[i] == G);
    cout_d = (op(kf[WIDTH], kf[0]) == G);
  end
  // whole pipeline advances in lockstep whenever the output slot is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NG; g++) begin
        v_q[g] <= 1'b0;
        k_q[g] <= '0;
        p_q[g] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef KPG_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (en) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        k_q[0] <= k0;
        p_q[0] <= a ^ b;
      end
      for (int g = 1; g < NG; g++) begin
        v_q[g] <= v_q[g-1];
        k_q[g] <= levels(k_q[g-1], (g - 1) * REG_EVERY, g * REG_EVERY);
        p_q[g] <= p_q[g-1];
      end
      out_valid <= v_q[NG-1];
      if (v_q[NG-1]) begin
        sum  <= p_q[NG-1] ^ c;
        cout <= cout_d;
`ifdef KPG_OVF_EN
        ovf  <= c[WIDTH-1] ^ cout_d;
`endif
      end
    end
  end
endmodule

// File: tb/tb_kpg_prefix_adder_pipe.sv
// tb_kpg_prefix_adder_pipe: scoreboard bench for kpg_prefix_adder_pipe (WIDTH=32, REG_EVERY=1)
module tb_kpg_prefix_adder_pipe;
  localparam int W = 32, RE = 1, LAT = 6;
  logic clk = 0, rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  logic rand_rdy;
  int checks = 0, errors = 0, cyc = 0, last_lat = -1;
  int oc[$];
  typedef struct {logic [W-1:0] s; logic c; logic o; int cyc;} exp_t;
  exp_t q[$];

  kpg_prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(RE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
`ifdef KPG_OVF_EN
    .sum(sum), .cout(cout), .ovf(ovf)
`else
    .sum(sum), .cout(cout)
`endif
  );
`ifndef KPG_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, want);
    end
  endtask

  // randomised output backpressure
  always @(posedge clk) if (rand_rdy) begin
    #1;
    out_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: records accepted beats with their expected result, checks emitted results
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    logic [W:0] full;
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
    chk("inflight_le_lat", q.size() <= LAT, 1'b1);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got sum %0h want no output", sum);
      end else begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
`ifdef KPG_OVF_EN
        chk("ovf", ovf, e.o);
`endif
        last_lat = cyc - e.cyc;
        oc.push_back(cyc);
      end
    end
    if (in_valid && in_ready) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.s = full[W-1:0];
      e.c = full[W];
      e.o = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      e.cyc = cyc;
      q.push_back(e);
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int n = 0;
    in_valid = 1;
    a = x;
    b = y;
    cin = ci;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready 0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0; rand_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    send(32'hFFFFFFFF, 32'h0, 1'b1);
    drain();
    chk("t1_latency", last_lat, LAT);
    oc.delete();
    send(32'h1, 32'h2, 1'b0);
    send(32'h5, 32'h5, 1'b1);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    drain();
    chk("t2_count", oc.size(), 3);
    if (oc.size() == 3) chk("t2_consecutive", oc[2] - oc[0], 2);
    oc.delete();
    fork
      for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    chk("t3_count", oc.size(), 8);
    oc.delete();
    send(32'h10, 32'h20, 1'b0);
    send(32'h30, 32'h40, 1'b1);
    send(32'h50, 32'h60, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_valid_before_rst", out_valid, 1);
    rst_n = 0;
    #1;
    chk("t4_valid_in_rst", out_valid, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("t4_no_output", oc.size(), 0);
    @(posedge clk);
    #1;
`ifdef KPG_OVF_EN
    send(32'h7FFFFFFF, 32'h1, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b0);
    drain();
`endif
    rand_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] x;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      x = $urandom;
      send(x, ($urandom_range(0, 3) == 0) ? ~x : $urandom, 1'($urandom_range(0, 1)));
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
